fetch_pc_sequencer: RTL and testbench

Owns the architectural fetch PC and sequences instruction fetch over a single-outstanding request/grant/response instruction-memory port. It presents one fetched instruction at a time to decode through a valid/stall slot. It selects the next PC from PC+4, a branch/jump redirect, or a trap vector, and it discards responses that were already in flight when a redirect arrives. It sits between the IF-stage PC+4 incrementer and the IF/ID boundary of the RISC-V core.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_sequencer_pc_plus4.sv | 12 +
 rtl/fetch_pc_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_pc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding, NOP filler and default boot address.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HALTED
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] BOOT_ADDR_C = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_sequencer_pc_plus4.sv
// IF-stage PC+4 incrementer.
// Wraps modulo 2^XLEN with no carry out.
module PC_Plus4 #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: single-outstanding imem sequencer feeding
// one decode slot, with redirect/trap steering and kill.
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = BOOT_ADDR_C,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            reset,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemGnt,
  input  logic            IMemRValid,
  input  logic [31:0]     IMemRData,
  output logic            InstrValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  input  logic            StallF,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectTarget,
  input  logic            Trap,
  input  logic [XLEN-1:0] TrapVector,
  input  logic            Halt,
  output logic            Halted
);

  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state, state_n, req_or_halt;
  logic [XLEN-1:0] pc, pc_plus4, tgt;
  logic            kill, flush, rsp, consume;

  PC_Plus4 #(.XLEN(XLEN)) u_pc_plus4 (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign flush    = Trap | Redirect;
  assign tgt      = (Trap ? TrapVector : RedirectTarget) & ALIGN;
  assign rsp      = (state == S_WAIT) & IMemRValid;
  assign consume  = (state == S_DRAIN) & ~StallF;
  assign IMemAddr = pc;

  // Halt is sampled whenever a fresh request would start.
  assign req_or_halt = Halt ? S_HALTED : S_REQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   state_n = flush ? S_REQ : req_or_halt;
      S_REQ:    if (IMemGnt) state_n = S_WAIT;
      S_WAIT: begin
        if (flush) begin
          if (IMemRValid) state_n = S_REQ;
        end else if (IMemRValid) begin
          state_n = kill ? req_or_halt : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (flush)        state_n = S_REQ;
        else if (!StallF) state_n = req_or_halt;
      end
      S_HALTED: if (flush) state_n = S_REQ;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    IMemReq = (state == S_REQ);
    Halted  = (state == S_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= BOOT_ADDR;
      kill        <= 1'b0;
      InstrValidD <= 1'b0;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
    end else if (flush) begin
      pc          <= tgt;
      InstrValidD <= 1'b0;
      InstrD      <= NOP_INSTR;
      // A request already granted must have its response dropped.
      if (((state == S_REQ) && IMemGnt) ||
          ((state == S_WAIT) && !IMemRValid))
        kill <= 1'b1;
      else if (rsp)
        kill <= 1'b0;
    end else if (rsp) begin
      if (kill) begin
        kill <= 1'b0;
      end else begin
        InstrD      <= IMemRData;
        PCD         <= pc;
        PCPlus4D    <= pc_plus4;
        InstrValidD <= 1'b1;
        pc          <= pc_plus4;
      end
    end else if (consume) begin
      InstrValidD <= 1'b0;
      InstrD      <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: cycle table
// plus hand sequences for reset-in-flight and kill cases.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] N = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt = 1'b0;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = '0;
  logic        InstrValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        StallF = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectTarget = '0;
  logic        Trap = 1'b0;
  logic [31:0] TrapVector = '0;
  logic        Halt = 1'b0;
  logic        Halted;

  int total = 0;
  int passed = 0;

  fetch_pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemGnt        (IMemGnt),
    .IMemRValid     (IMemRValid),
    .IMemRData      (IMemRData),
    .InstrValidD    (InstrValidD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .StallF         (StallF),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Trap           (Trap),
    .TrapVector     (TrapVector),
    .Halt           (Halt),
    .Halted         (Halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4d;
    logic        hlt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic        trap;
    logic [31:0] rtgt;
    logic [31:0] ttgt;
    logic        halt;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(
    logic req, logic [31:0] addr, logic vld, logic [31:0] instr,
    logic [31:0] pcd, logic [31:0] p4d, logic hlt,
    logic gnt, logic rv, logic [31:0] rdata, logic stall,
    logic redir, logic trap, logic [31:0] rtgt,
    logic [31:0] ttgt, logic halt);
    vec_t v;
    v.req = req;     v.addr = addr;   v.vld = vld;
    v.instr = instr; v.pcd = pcd;     v.p4d = p4d;
    v.hlt = hlt;     v.gnt = gnt;     v.rv = rv;
    v.rdata = rdata; v.stall = stall; v.redir = redir;
    v.trap = trap;   v.rtgt = rtgt;   v.ttgt = ttgt;
    v.halt = halt;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s: got %h expected %h", n, a, e);
    else
      passed++;
  endtask

  task automatic chk_all(string t, logic req, logic [31:0] addr,
    logic vld, logic [31:0] instr, logic [31:0] pcd,
    logic [31:0] p4d, logic hlt);
    chk({t, ".req"},    32'(IMemReq),     32'(req));
    chk({t, ".addr"},   IMemAddr,         addr);
    chk({t, ".vld"},    32'(InstrValidD), 32'(vld));
    chk({t, ".instr"},  InstrD,           instr);
    chk({t, ".pcd"},    PCD,              pcd);
    chk({t, ".p4d"},    PCPlus4D,         p4d);
    chk({t, ".halted"}, 32'(Halted),      32'(hlt));
  endtask

  task automatic drive(logic gnt, logic rv, logic [31:0] rdata,
    logic stall, logic redir, logic trap, logic [31:0] rtgt,
    logic [31:0] ttgt, logic halt);
    IMemGnt = gnt;  IMemRValid = rv; IMemRData = rdata;
    StallF = stall; Redirect = redir; Trap = trap;
    RedirectTarget = rtgt; TrapVector = ttgt; Halt = halt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0, 32'h0,   0, N, 32'h0, 32'h0, 0, 0,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[1]  = mk(1, 32'h0,   0, N, 32'h0, 32'h0, 0, 1,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[2]  = mk(0, 32'h0,   0, N, 32'h0, 32'h0, 0, 0,1,32'h00500093, 0,0,0,32'h0,0,0);
    tbl[3]  = mk(0, 32'h4,   1, 32'h00500093, 32'h0, 32'h4, 0, 0,0,32'h0, 0,0,0,32'h0,0,0);
    tbl[4]  = mk(1, 32'h4,   0, N, 32'h0, 32'h4, 0, 1,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[5]  = mk(0, 32'h4,   0, N, 32'h0, 32'h4, 0, 0,1,32'h00100113, 0,0,0,32'h0,0,0);
    for (int i = 6; i < 10; i++)
      tbl[i] = mk(0, 32'h8, 1, 32'h00100113, 32'h4, 32'h8, 0, 0,0,32'h0, 1,0,0,32'h0,0,0);
    tbl[10] = mk(0, 32'h8,   1, 32'h00100113, 32'h4, 32'h8, 0, 0,0,32'h0, 0,0,0,32'h0,0,0);
    tbl[11] = mk(1, 32'h8,   0, N, 32'h4, 32'h8, 0, 1,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[12] = mk(0, 32'h8,   0, N, 32'h4, 32'h8, 0, 0,0,32'h0,        0,1,0,32'h100,0,0);
    tbl[13] = mk(0, 32'h100, 0, N, 32'h4, 32'h8, 0, 0,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[14] = mk(0, 32'h100, 0, N, 32'h4, 32'h8, 0, 0,1,32'hDEADBEEF, 0,0,0,32'h0,0,0);
    tbl[15] = mk(1, 32'h100, 0, N, 32'h4, 32'h8, 0, 1,0,32'h0,        0,0,0,32'h0,0,0);
    tbl[16] = mk(0, 32'h100, 0, N, 32'h4, 32'h8, 0, 0,1,32'h00A00193, 0,0,0,32'h0,0,0);
    tbl[17] = mk(0, 32'h104, 1, 32'h00A00193, 32'h100, 32'h104, 0, 0,0,32'h0, 1,1,1,32'h200,32'h80,0);
    tbl[18] = mk(1, 32'h80,  0, N, 32'h100, 32'h104, 0, 0,0,32'h0,    0,1,0,32'hFFFFFFFF,0,0);
    tbl[19] = mk(1, 32'hFFFFFFFC, 0, N, 32'h100, 32'h104, 0, 1,0,32'h0, 0,0,0,32'h0,0,0);
    tbl[20] = mk(0, 32'hFFFFFFFC, 0, N, 32'h100, 32'h104, 0, 0,1,32'h33, 0,0,0,32'h0,0,0);
    tbl[21] = mk(0, 32'h0,   1, 32'h33, 32'hFFFFFFFC, 32'h0, 0, 0,0,32'h0, 1,0,0,32'h0,0,1);
    tbl[22] = mk(0, 32'h0,   1, 32'h33, 32'hFFFFFFFC, 32'h0, 0, 0,0,32'h0, 0,0,0,32'h0,0,1);
    tbl[23] = mk(0, 32'h0,   0, N, 32'hFFFFFFFC, 32'h0, 1, 0,1,32'h55, 0,0,0,32'h0,0,1);
    tbl[24] = mk(0, 32'h0,   0, N, 32'hFFFFFFFC, 32'h0, 1, 0,0,32'h0,  0,0,0,32'h0,0,0);
    tbl[25] = mk(0, 32'h0,   0, N, 32'hFFFFFFFC, 32'h0, 1, 0,0,32'h0,  0,1,0,32'h40,0,0);
    tbl[26] = mk(1, 32'h40,  0, N, 32'hFFFFFFFC, 32'h0, 0, 1,0,32'h0,  0,0,0,32'h0,0,0);
    tbl[27] = mk(0, 32'h40,  0, N, 32'hFFFFFFFC, 32'h0, 0, 0,1,32'h12345678, 0,0,0,32'h0,0,0);
    tbl[28] = mk(0, 32'h44,  1, 32'h12345678, 32'h40, 32'h44, 0, 1,0,32'h0, 0,0,0,32'h0,0,0);
    tbl[29] = mk(1, 32'h44,  0, N, 32'h40, 32'h44, 0, 1,0,32'h0,  0,0,0,32'h0,0,0);

    repeat (2) @(negedge clk);
    chk_all("rst", 0, 32'h0, 0, N, 32'h0, 32'h0, 0);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      chk_all($sformatf("v%0d", i), tbl[i].req, tbl[i].addr,
              tbl[i].vld, tbl[i].instr, tbl[i].pcd, tbl[i].p4d,
              tbl[i].hlt);
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].stall,
            tbl[i].redir, tbl[i].trap, tbl[i].rtgt, tbl[i].ttgt,
            tbl[i].halt);
      @(negedge clk);
    end

    // Reset while a response is outstanding; stale data follows.
    chk_all("wait44", 0, 32'h44, 0, N, 32'h40, 32'h44, 0);
    drive(0,0,32'h0, 0,0,0,32'h0,32'h0, 0);
    reset = 1'b1;
    #1;
    chk_all("arst", 0, 32'h0, 0, N, 32'h0, 32'h0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0,1,32'h00000BAD, 0,0,0,32'h0,32'h0, 0);
    chk_all("idle2", 0, 32'h0, 0, N, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_all("req2", 1, 32'h0, 0, N, 32'h0, 32'h0, 0);
    drive(0,1,32'h00000BAD, 0,0,0,32'h0,32'h0, 0);
    @(negedge clk);
    chk_all("req2h", 1, 32'h0, 0, N, 32'h0, 32'h0, 0);

    // Redirect with same-cycle grant: response must be killed.
    drive(1,0,32'h0, 0,1,0,32'h300,32'h0, 0);
    @(negedge clk);
    chk_all("kgnt", 0, 32'h300, 0, N, 32'h0, 32'h0, 0);
    drive(0,1,32'h00000BD2, 0,0,0,32'h0,32'h0, 0);
    @(negedge clk);
    chk_all("kdrop", 1, 32'h300, 0, N, 32'h0, 32'h0, 0);
    drive(1,0,32'h0, 0,0,0,32'h0,32'h0, 0);
    @(negedge clk);

    // Redirect with same-cycle response: data discarded.
    drive(0,1,32'h00000777, 0,1,0,32'h500,32'h0, 0);
    @(negedge clk);
    chk_all("rvred", 1, 32'h500, 0, N, 32'h0, 32'h0, 0);
    drive(1,0,32'h0, 0,0,0,32'h0,32'h0, 0);
    @(negedge clk);
    drive(0,1,32'h00000513, 0,0,0,32'h0,32'h0, 0);
    @(negedge clk);
    chk_all("deliv", 0, 32'h504, 1, 32'h00000513, 32'h500, 32'h504, 0);
    drive(0,0,32'h0, 0,0,0,32'h0,32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
